// File: rtl/spi_reg_peripheral.sv
// Write-only SPI mode-0 peripheral: synchronises the pad inputs, shifts in 16-bit frames
// and commits {wr, addr[6:0], data[7:0]} into five 8-bit configuration registers.
module spi_reg_peripheral #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk_in,
    input  logic       copi_in,
    input  logic       ncs_in,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_done,
    output logic       frame_error
);

    localparam int unsigned NumRegs = 5;

    typedef enum logic [1:0] {StIdle, StRecv, StCommit} state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, copi_sync_q, ncs_sync_q;
    logic                   sclk_hist_q, ncs_hist_q;
    logic                   sclk_s, copi_s, ncs_s;
    logic                   sclk_rise, ncs_rise, ncs_fall;

    logic [15:0] shift_q, shift_d;
    logic [4:0]  count_q, count_d;
    logic        commit_wr, commit_err;
    logic        done_q, error_q;
    logic [7:0]  regs_q [NumRegs];

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign copi_s = copi_sync_q[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];

    assign sclk_rise = sclk_s & ~sclk_hist_q;
    assign ncs_rise  = ncs_s & ~ncs_hist_q;
    assign ncs_fall  = ~ncs_s & ncs_hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '0;
            sclk_hist_q <= 1'b0;
            ncs_hist_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_in};
            copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi_in};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs_in};
            sclk_hist_q <= sclk_s;
            ncs_hist_q  <= ncs_s;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        count_d    = count_q;
        commit_wr  = 1'b0;
        commit_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ncs_fall) begin
                    shift_d = '0;
                    count_d = '0;
                    state_d = StRecv;
                end
            end
            StRecv: begin
                // Shift happens before the commit decision when both edges coincide.
                if (sclk_rise && count_q < 5'd17) begin
                    count_d = count_q + 5'd1;
                    if (count_q < 5'd16) begin
                        shift_d = {shift_q[14:0], copi_s};
                    end
                end
                if (ncs_rise) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                if (count_q == 5'd16) begin
                    commit_wr = shift_q[15] && (32'(shift_q[14:8]) <= MAX_ADDR);
                end else begin
                    commit_err = 1'b1;
                end
                state_d = StIdle;
                // A new frame may already be starting; do not drop its falling edge.
                if (ncs_fall) begin
                    shift_d = '0;
                    count_d = '0;
                    state_d = StRecv;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            count_q <= count_d;
            done_q  <= commit_wr;
            error_q <= commit_err;
            for (int i = 0; i < NumRegs; i++) begin
                if (commit_wr && shift_q[14:8] == 7'(i)) begin
                    regs_q[i] <= shift_q[7:0];
                end
            end
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_done      = done_q;
    assign frame_error     = error_q;

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// Directed bench for spi_reg_peripheral: drives SPI frames on the pads and checks the
// register file, pulse counts and commit latency against hand-computed values.
module tb_spi_reg_peripheral;

    localparam time HalfSclk = 50ns;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk_in = 1'b0;
    logic       copi_in = 1'b0;
    logic       ncs_in = 1'b1;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_done, frame_error;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    spi_reg_peripheral #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sclk_in        (sclk_in),
        .copi_in        (copi_in),
        .ncs_in         (ncs_in),
        .en_reg_out_7_0 (en_reg_out_7_0),
        .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0 (en_reg_pwm_7_0),
        .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle (pwm_duty_cycle),
        .frame_done     (frame_done),
        .frame_error    (frame_error)
    );

    always #5ns clk = ~clk;

    always @(posedge clk) begin
        if (frame_done) done_cnt++;
        if (frame_error) err_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            copi_in = bits[i];
            #HalfSclk sclk_in = 1'b1;
            #HalfSclk sclk_in = 1'b0;
        end
    endtask

    // nCS low, n bits MSB first, nCS high, then two SCLK periods of idle gap.
    task automatic send_frame(input logic [31:0] bits, input int n);
        ncs_in = 1'b0;
        #HalfSclk;
        shift_bits(bits, n - 1, 0);
        #HalfSclk ncs_in = 1'b1;
        #(4 * HalfSclk);
    endtask

    task automatic check_regs(input string tag, input logic [39:0] exp);
        check_eq({tag, " r0"}, 32'(en_reg_out_7_0), 32'(exp[7:0]));
        check_eq({tag, " r1"}, 32'(en_reg_out_15_8), 32'(exp[15:8]));
        check_eq({tag, " r2"}, 32'(en_reg_pwm_7_0), 32'(exp[23:16]));
        check_eq({tag, " r3"}, 32'(en_reg_pwm_15_8), 32'(exp[31:24]));
        check_eq({tag, " r4"}, 32'(pwm_duty_cycle), 32'(exp[39:32]));
    endtask

    initial begin
        int d0, e0, lat;
        logic [31:0] f;

        repeat (4) @(posedge clk);
        #1 check_regs("reset", 40'h0);
        check_eq("reset done", 32'(frame_done), 32'd0);
        check_eq("reset error", 32'(frame_error), 32'd0);
        rst = 1'b0;
        repeat (4) @(posedge clk);

        // 1: single write to address 0
        d0 = done_cnt; e0 = err_cnt;
        send_frame(32'h80F0, 16);
        check_regs("t1", 40'h00_00_00_00_F0);
        check_eq("t1 done", 32'(done_cnt - d0), 32'd1);
        check_eq("t1 err", 32'(err_cnt - e0), 32'd0);

        // 2: back-to-back writes
        d0 = done_cnt;
        send_frame(32'h8480, 16);
        send_frame(32'h83A5, 16);
        check_regs("t2", 40'h80_A5_00_00_F0);
        check_eq("t2 done", 32'(done_cnt - d0), 32'd2);

        // 3: read frame and out-of-range address are discarded silently
        d0 = done_cnt; e0 = err_cnt;
        send_frame(32'h00FF, 16);
        send_frame(32'h9055, 16);
        check_regs("t3", 40'h80_A5_00_00_F0);
        check_eq("t3 done", 32'(done_cnt - d0), 32'd0);
        check_eq("t3 err", 32'(err_cnt - e0), 32'd0);

        // 4: short and long frames raise frame_error only
        d0 = done_cnt; e0 = err_cnt;
        send_frame(32'h813C >> 1, 15);
        send_frame(32'h813C << 1, 17);
        check_eq("t4 r1", 32'(en_reg_out_15_8), 32'h00);
        check_eq("t4 err", 32'(err_cnt - e0), 32'd2);
        check_eq("t4 done", 32'(done_cnt - d0), 32'd0);

        // 5: reset after bit 9 discards the frame and clears all registers
        d0 = done_cnt; e0 = err_cnt;
        f = 32'h8222;
        ncs_in = 1'b0;
        #HalfSclk;
        shift_bits(f, 15, 7);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        shift_bits(f, 6, 0);
        #HalfSclk ncs_in = 1'b1;
        #(4 * HalfSclk);
        check_regs("t5a", 40'h0);
        check_eq("t5a done", 32'(done_cnt - d0), 32'd0);
        check_eq("t5a err", 32'(err_cnt - e0), 32'd0);
        send_frame(32'h8211, 16);
        check_eq("t5b r2", 32'(en_reg_pwm_7_0), 32'h11);
        check_eq("t5b done", 32'(done_cnt - d0), 32'd1);

        // 6: latency from nCS rising to register update
        f = 32'h8011;
        ncs_in = 1'b0;
        #HalfSclk;
        shift_bits(f, 15, 0);
        #HalfSclk;
        @(posedge clk); #1 ncs_in = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (lat == 0 && en_reg_out_7_0 == 8'h11) lat = k;
        end
        check_eq("t6 latency", 32'(lat), 32'd4);

        // SCLK activity with nCS high must not change anything
        d0 = done_cnt; e0 = err_cnt;
        shift_bits(32'hFFFF_FFFF, 15, 0);
        #(4 * HalfSclk);
        check_regs("t6 idle", 40'h00_00_11_00_11);
        check_eq("t6 idle done", 32'(done_cnt - d0), 32'd0);
        check_eq("t6 idle err", 32'(err_cnt - e0), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
